conv_stream_ctrl: RTL and testbench

Stream controller that sequences the 4-lane convolver datapath (subframe plus four conv_2d) between an AXI4-Stream slave input and an AXI4-Stream master output. It counts columns per frame and feeds the convolver only when output space is guaranteed, because the convolver pipeline cannot stall. It discards priming results, tags valid results through the fixed convolver latency, buffers them in an output FIFO, and generates TLAST. It also latches the kernel select per frame and clears the convolver between frames.

---
 rtl/conv_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: paces a non-stallable 4-lane convolver between AXI4-Stream ports, tagging results into an output FIFO
module conv_stream_ctrl #(
    parameter int IMAGE_HEIGHT = 200,
    parameter int IMAGE_WIDTH  = 200,
    parameter int KERNEL_WIDTH = 3,
    parameter int NB_DATA      = 32,
    parameter int PIPE_LAT     = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [1:0]         i_kernel_sel,
    input  logic [NB_DATA-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic [NB_DATA-1:0] m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    output logic [NB_DATA-1:0] o_conv_data,
    output logic               o_conv_valid,
    output logic               o_conv_clear,
    output logic [1:0]         o_kernel_sel,
    input  logic [NB_DATA-1:0] i_conv_data,
    output logic               o_frame_err
);
    localparam int WPC         = IMAGE_HEIGHT / 4;
    localparam int IN_WORDS    = IMAGE_WIDTH * WPC;
    localparam int PRIME_WORDS = (KERNEL_WIDTH - 1) * WPC;
    localparam int CW          = $clog2(IN_WORDS + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int NW          = AW + 1;
    localparam int OW          = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       in_cnt_q, in_cnt_d;
    logic [NB_DATA-1:0]  conv_data_q, conv_data_d;
    logic                conv_valid_q, conv_valid_d;
    logic                conv_tag_q, conv_tag_d;
    logic                conv_last_q, conv_last_d;
    logic [PIPE_LAT-1:0] tag_pipe_q, tag_pipe_d;
    logic [PIPE_LAT-1:0] last_pipe_q, last_pipe_d;
    logic [PIPE_LAT:0]   tag_ext, last_ext;
    logic                clear_q, clear_d;
    logic                err_q, err_d;
    logic [1:0]          ksel_q, ksel_d;
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [NB_DATA:0]    mem_q [FIFO_DEPTH];
    logic [OW-1:0]       outstanding;
    logic                room, ready, accept, fin, push, pop, pipe_empty;

    // Flow control: a tagged word is only fed when FIFO occupancy plus every tagged word still in flight leaves a free slot
    always_comb begin
        outstanding = OW'(cnt_q) + OW'($countones({tag_pipe_q, conv_tag_q}));
        room        = outstanding < OW'(FIFO_DEPTH);
        ready       = !i_reset && state_q != DRAIN && (room || (state_q == RUN && in_cnt_q < CW'(PRIME_WORDS)));
        accept      = s_tvalid && ready;
        fin         = in_cnt_q == CW'(IN_WORDS - 1);
        push        = tag_pipe_q[PIPE_LAT-1];
        pop         = cnt_q != '0 && m_tready;
        pipe_empty  = !conv_valid_q && tag_pipe_q == '0;
    end

    // Frame sequencing: column count, kernel latch, framing errors and the between-frame convolver clear
    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        ksel_d   = (state_q == IDLE && accept) ? i_kernel_sel : ksel_q;
        err_d    = err_q || (accept && (s_tlast != fin));
        clear_d  = state_q == DRAIN && pipe_empty;
        if (accept) begin
            in_cnt_d = in_cnt_q + 1'b1;
            state_d  = (s_tlast || fin) ? DRAIN : RUN;
        end
        if (clear_d) begin
            in_cnt_d = '0;
            state_d  = IDLE;
        end
    end

    // Convolver feed, result tag pipe aligned to the convolver latency, and FIFO pointers
    always_comb begin
        conv_valid_d = accept;
        conv_data_d  = accept ? s_tdata : conv_data_q;
        conv_tag_d   = accept && in_cnt_q >= CW'(PRIME_WORDS);
        conv_last_d  = accept && (fin || s_tlast);
        tag_ext      = {tag_pipe_q, conv_tag_q};
        last_ext     = {last_pipe_q, conv_last_q};
        tag_pipe_d   = tag_ext[PIPE_LAT-1:0];
        last_pipe_d  = last_ext[PIPE_LAT-1:0];
        wr_d         = wr_q + AW'(push);
        rd_d         = rd_q + AW'(pop);
        cnt_d        = cnt_q + NW'(push) - NW'(pop);
    end

    // Control and pipeline registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            in_cnt_q     <= '0;
            conv_data_q  <= '0;
            conv_valid_q <= 1'b0;
            conv_tag_q   <= 1'b0;
            conv_last_q  <= 1'b0;
            tag_pipe_q   <= '0;
            last_pipe_q  <= '0;
            clear_q      <= 1'b0;
            err_q        <= 1'b0;
            ksel_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            conv_data_q  <= conv_data_d;
            conv_valid_q <= conv_valid_d;
            conv_tag_q   <= conv_tag_d;
            conv_last_q  <= conv_last_d;
            tag_pipe_q   <= tag_pipe_d;
            last_pipe_q  <= last_pipe_d;
            clear_q      <= clear_d;
            err_q        <= err_d;
            ksel_q       <= ksel_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
        end
    end

    // FIFO storage: convolver result with its end-of-frame bit
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= {last_pipe_q[PIPE_LAT-1], i_conv_data};
    end

    assign s_tready     = ready;
    assign m_tvalid     = cnt_q != '0;
    assign m_tdata      = m_tvalid ? mem_q[rd_q][NB_DATA-1:0] : '0;
    assign m_tlast      = m_tvalid && mem_q[rd_q][NB_DATA];
    assign o_conv_data  = conv_data_q;
    assign o_conv_valid = conv_valid_q;
    assign o_conv_clear = clear_q;
    assign o_kernel_sel = ksel_q;
    assign o_frame_err  = err_q;
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: frame-scenario table, corner sequences and random frames against a frame-level scoreboard
module tb_conv_stream_ctrl;
    localparam int IN = 10, PRIME = 4, PL = 2;

    logic        clk = 1'b0, i_reset = 1'b0;
    logic [1:0]  i_kernel_sel = '0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready = 1'b1;
    logic [31:0] o_conv_data, i_conv_data, c1, c2;
    logic        o_conv_valid, o_conv_clear, o_frame_err;
    logic [1:0]  o_kernel_sel;

    conv_stream_ctrl #(.IMAGE_HEIGHT(8), .IMAGE_WIDTH(5), .KERNEL_WIDTH(3), .NB_DATA(32), .PIPE_LAT(PL), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_kernel_sel(i_kernel_sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid), .o_conv_clear(o_conv_clear),
        .o_kernel_sel(o_kernel_sel), .i_conv_data(i_conv_data), .o_frame_err(o_frame_err));

    always #5 clk = ~clk;

    // Convolver stand-in: two-cycle delay of data+1
    always @(posedge clk) begin
        c1 <= o_conv_data;
        c2 <= c1;
    end
    assign i_conv_data = c2 + 32'd1;

    typedef struct {
        int         len;
        int         tl;
        logic [1:0] ks;
        bit         rdy;
        bit         gaps;
        int         exp_out;
        int         exp_last;
        bit         exp_err;
    } vec_t;

    logic [32:0] exp_q[$];
    int  idx = 0, acc_cnt = 0, out_cnt = 0, last_cnt = 0, clr_cnt = 0, fend_cnt = 0;
    int  cyc = 0, t_acc = -1, t_vld = -1;
    int  pass_cnt = 0, total_cnt = 0;
    bit  err_m = 1'b0, rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [95:0] outs();
        return {24'd0, s_tready, m_tdata, m_tvalid, m_tlast, o_conv_data, o_conv_valid, o_conv_clear, o_kernel_sel, o_frame_err};
    endfunction

    // Frame-level reference: beats past priming become outputs (data+1), frame ends on tlast or the final column
    always @(negedge clk) begin
        cyc++;
        if (i_reset) begin
            exp_q.delete();
            idx = 0; err_m = 1'b0; t_acc = -1; t_vld = -1;
        end else begin
            if (s_tvalid && s_tready) begin
                if (idx >= PRIME) exp_q.push_back({(idx == IN - 1) || s_tlast, s_tdata + 32'd1});
                if (idx == PRIME && t_acc < 0) t_acc = cyc;
                if (s_tlast != (idx == IN - 1)) err_m = 1'b1;
                acc_cnt++;
                if (s_tlast || idx == IN - 1) begin
                    fend_cnt++;
                    idx = 0;
                end else idx++;
            end
            if (m_tvalid && t_vld < 0) t_vld = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) chk("extra_out", 0, 1);
                else chk("out_word", {m_tlast, m_tdata}, exp_q.pop_front());
                out_cnt++;
                if (m_tlast) last_cnt++;
            end
            if (o_conv_clear) clr_cnt++;
        end
    end

    // Random output backpressure when enabled
    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
    end

    task automatic clr_stats();
        acc_cnt = 0; out_cnt = 0; last_cnt = 0; clr_cnt = 0; fend_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_reset = 1'b1;
        #1 chk("reset_outs", outs(), 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        clr_stats();
    endtask

    task automatic idle_in();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_acc();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_tready) break;
            if (n >= 100) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int len, input int tl, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                idle_in();
                @(posedge clk); #1;
            end
            s_tdata  = $urandom;
            s_tlast  = (i == tl);
            s_tvalid = 1'b1;
            wait_acc();
        end
    endtask

    task automatic wait_drain(input int nclr);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && clr_cnt >= nclr && !m_tvalid) break;
            if (n >= 600) begin
                chk("drain_timeout", n, 0);
                break;
            end
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    vec_t vt[6];
    int   r, len, tl;
    logic [1:0] ks;

    initial begin
        vt[0] = '{10,  9, 2'd1, 1'b0, 1'b0, 6, 1, 1'b0};
        vt[1] = '{ 7,  6, 2'd2, 1'b0, 1'b0, 3, 1, 1'b1};
        vt[2] = '{ 3,  2, 2'd3, 1'b1, 1'b1, 0, 0, 1'b1};
        vt[3] = '{10, -1, 2'd0, 1'b1, 1'b1, 6, 1, 1'b1};
        vt[4] = '{ 5,  4, 2'd2, 1'b1, 1'b0, 1, 1, 1'b1};
        vt[5] = '{10,  9, 2'd3, 1'b1, 1'b1, 6, 1, 1'b0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            rnd_rdy = vt[i].rdy;
            i_kernel_sel = vt[i].ks;
            send_frame(vt[i].len, vt[i].tl, vt[i].gaps);
            idle_in();
            wait_drain(1);
            rnd_rdy = 1'b0;
            m_tready = 1'b1;
            chk("out_count", out_cnt, vt[i].exp_out);
            chk("tlast_count", last_cnt, vt[i].exp_last);
            chk("frame_err", o_frame_err, vt[i].exp_err);
            chk("kernel_sel", o_kernel_sel, vt[i].ks);
            chk("clear_pulses", clr_cnt, 1);
            chk("ready_after_frame", s_tready, 1);
            if (vt[i].exp_out > 0) chk("first_latency", t_vld - t_acc, PL + 2);
        end

        // Output stalled: priming plus FIFO_DEPTH beats accepted, then release
        do_reset();
        m_tready = 1'b0;
        fork
            send_frame(10, 9, 1'b0);
            begin
                repeat (30) @(negedge clk);
                chk("stall_accepted", acc_cnt, 8);
                chk("stall_ready", s_tready, 0);
                chk("stall_valid", m_tvalid, 1);
                m_tready = 1'b1;
            end
        join
        idle_in();
        wait_drain(1);
        chk("stall_out_count", out_cnt, 6);

        // Kernel select changed mid-frame, then latched by the next frame
        do_reset();
        i_kernel_sel = 2'd2;
        fork
            send_frame(10, 9, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 i_kernel_sel = 2'd3;
            end
        join
        idle_in();
        wait_drain(1);
        chk("ksel_held", o_kernel_sel, 2);
        send_frame(10, 9, 1'b0);
        idle_in();
        wait_drain(2);
        chk("ksel_next", o_kernel_sel, 3);
        chk("ksel_outs", out_cnt, 12);

        // Reset asserted while the sixth beat is offered
        do_reset();
        i_kernel_sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = $urandom; s_tlast = 1'b0; s_tvalid = 1'b1;
            wait_acc();
        end
        s_tdata = $urandom;
        #1 i_reset = 1'b1;
        #1 chk("midframe_reset_outs", outs(), 0);
        idle_in();
        @(posedge clk); #1;
        i_reset = 1'b0;
        clr_stats();
        send_frame(10, 9, 1'b0);
        idle_in();
        wait_drain(1);
        chk("post_reset_outs", out_cnt, 6);
        chk("post_reset_err", o_frame_err, 0);

        // Back-to-back frames, kernel select relatched
        do_reset();
        i_kernel_sel = 2'd2;
        send_frame(10, 9, 1'b0);
        i_kernel_sel = 2'd1;
        send_frame(10, 9, 1'b0);
        idle_in();
        wait_drain(2);
        chk("b2b_outs", out_cnt, 12);
        chk("b2b_lasts", last_cnt, 2);
        chk("b2b_ksel", o_kernel_sel, 1);
        chk("b2b_clears", clr_cnt, 2);
        chk("b2b_err", o_frame_err, 0);

        // Random frames, gaps and backpressure
        do_reset();
        rnd_rdy = 1'b1;
        ks = '0;
        for (int j = 0; j < 25; j++) begin
            r = $urandom_range(0, 7);
            len = (r == 1) ? $urandom_range(1, 9) : 10;
            tl = (r == 0) ? -1 : len - 1;
            ks = 2'($urandom);
            i_kernel_sel = ks;
            send_frame(len, tl, 1'b1);
            idle_in();
        end
        wait_drain(25);
        rnd_rdy = 1'b0;
        m_tready = 1'b1;
        chk("rand_clears", clr_cnt, fend_cnt);
        chk("rand_err", o_frame_err, err_m);
        chk("rand_ksel", o_kernel_sel, ks);
        chk("rand_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
